// File: rtl/csa_sub16_pipe_if.sv
// Operand/result bus for the pipelined 16-bit carry-select subtractor.
// The master drives operands and result backpressure. The slave is the subtractor.
interface csa_sub16_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/csa_sub16_pipe.sv
// Two-stage pipelined 16-bit subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin.
// Carry-select groups are 2/2/3 bits in stage 1 and 4/5 bits in stage 2.
// Stage 1 resolves bits 6:0 and the carry into bit 7.
// Stage 2 resolves bits 15:7 and the flags.
module csa_sub16_pipe (
  input logic              clk,
  input logic              rst,
  csa_sub16_pipe_if.slave  bus
);

  // ---------------- flow control ----------------
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv       = !out_valid_reg || bus.out_ready;
  assign s1_adv       = !s1_valid_reg || s2_adv;
  assign bus.in_ready = s1_adv;

  // ---------------- stage 1 datapath: bits 6:0 ----------------
  logic [15:0] nb;
  logic        cin;
  logic [2:0]  g0_sum;                 // bits 1:0, rippled from cin
  logic [2:0]  g1_c0, g1_c1, g1_sel;   // bits 3:2
  logic [3:0]  g2_c0, g2_c1, g2_sel;   // bits 6:4

  assign nb  = ~bus.b;
  assign cin = ~bus.bin;

  assign g0_sum = {1'b0, bus.a[1:0]} + {1'b0, nb[1:0]} + {2'b00, cin};

  assign g1_c0  = {1'b0, bus.a[3:2]} + {1'b0, nb[3:2]};
  assign g1_c1  = {1'b0, bus.a[3:2]} + {1'b0, nb[3:2]} + 3'd1;
  assign g1_sel = g0_sum[2] ? g1_c1 : g1_c0;

  assign g2_c0  = {1'b0, bus.a[6:4]} + {1'b0, nb[6:4]};
  assign g2_c1  = {1'b0, bus.a[6:4]} + {1'b0, nb[6:4]} + 4'd1;
  assign g2_sel = g1_sel[2] ? g2_c1 : g2_c0;

  // ---------------- stage 1 registers ----------------
  logic [6:0] s1_diff_reg;
  logic       s1_c7_reg;
  logic [8:0] s1_a_hi_reg;
  logic [8:0] s1_nb_hi_reg;
  logic       s1_a15_reg;
  logic       s1_b15_reg;

  // Stage 1: capture the low-half result and the upper operand bits on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_diff_reg  <= '0;
      s1_c7_reg    <= 1'b0;
      s1_a_hi_reg  <= '0;
      s1_nb_hi_reg <= '0;
      s1_a15_reg   <= 1'b0;
      s1_b15_reg   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_diff_reg  <= {g2_sel[2:0], g1_sel[1:0], g0_sum[1:0]};
        s1_c7_reg    <= g2_sel[3];
        s1_a_hi_reg  <= bus.a[15:7];
        s1_nb_hi_reg <= nb[15:7];
        s1_a15_reg   <= bus.a[15];
        s1_b15_reg   <= bus.b[15];
      end
    end
  end

  // ---------------- stage 2 datapath: bits 15:7 ----------------
  logic [4:0]  g3_c0, g3_c1, g3_sel;   // bits 10:7
  logic [5:0]  g4_c0, g4_c1, g4_sel;   // bits 15:11
  logic [15:0] diff_next;
  logic        ovf_next;

  assign g3_c0  = {1'b0, s1_a_hi_reg[3:0]} + {1'b0, s1_nb_hi_reg[3:0]};
  assign g3_c1  = {1'b0, s1_a_hi_reg[3:0]} + {1'b0, s1_nb_hi_reg[3:0]} + 5'd1;
  assign g3_sel = s1_c7_reg ? g3_c1 : g3_c0;

  assign g4_c0  = {1'b0, s1_a_hi_reg[8:4]} + {1'b0, s1_nb_hi_reg[8:4]};
  assign g4_c1  = {1'b0, s1_a_hi_reg[8:4]} + {1'b0, s1_nb_hi_reg[8:4]} + 6'd1;
  assign g4_sel = g3_sel[4] ? g4_c1 : g4_c0;

  assign diff_next = {g4_sel[4:0], g3_sel[3:0], s1_diff_reg};
  assign ovf_next  = (s1_a15_reg != s1_b15_reg) && (diff_next[15] != s1_a15_reg);

  // ---------------- output registers ----------------
  logic [15:0] diff_reg;
  logic        bout_reg;
  logic        ovf_reg;
  logic        zero_reg;

  // Stage 2: load the finished word when the output slot is free or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      diff_reg      <= '0;
      bout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        diff_reg <= diff_next;
        bout_reg <= ~g4_sel[5];
        ovf_reg  <= ovf_next;
        zero_reg <= (diff_next == 16'h0000);
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_csa_sub16_pipe.sv
// Directed-vector and stream bench for csa_sub16_pipe.
module tb_csa_sub16_pipe;

  logic clk;
  logic rst;
  csa_sub16_pipe_if bus ();

  csa_sub16_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  localparam int NVEC = 12;
  vec_t vec [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: plain 17-bit subtraction; the top bit is the borrow.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    res_t r;
    logic [16:0] t;
    t    = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    r.d  = t[15:0];
    r.bo = t[16];
    r.ov = (a[15] != b[15]) && (r.d[15] != a[15]);
    r.z  = (r.d == 16'h0000);
    return r;
  endfunction

  // Single word with out_ready high; checks 2-cycle latency and all outputs.
  task automatic apply_vec(input int i);
    int lat;
    int wait_cnt;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = vec[i].a;
    bus.b         = vec[i].b;
    bus.bin       = vec[i].bin;
    #1;
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 10) begin
      @(negedge clk); #1; wait_cnt++;
    end
    chk("vec_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    chk("vec_latency", lat, 2);
    chk("vec_diff", {16'd0, bus.diff}, {16'd0, vec[i].diff});
    chk("vec_bout", {31'd0, bus.bout}, {31'd0, vec[i].bout});
    chk("vec_ovf",  {31'd0, bus.ovf},  {31'd0, vec[i].ovf});
    chk("vec_zero", {31'd0, bus.zero}, {31'd0, vec[i].zero});
    $display("vec %0d a=%h b=%h bin=%b -> diff=%h bout=%b ovf=%b zero=%b lat=%0d",
             i, vec[i].a, vec[i].b, vec[i].bin, bus.diff, bus.bout, bus.ovf, bus.zero, lat);
  endtask

  // Streaming run with a scoreboard. rnd=0: the first 8 table words back to back,
  // out_ready low on cycles 3..6. rnd=1: random operands, in_valid and out_ready.
  task automatic run_stream(input int nwords, input bit rnd, input int budget);
    res_t q[$];
    res_t exp_r;
    res_t held;
    int   sent;
    int   got;
    int   cyc;
    bit   have;
    bit   prev_stall;
    bit   exp_ir;
    logic [15:0] ca, cb;
    logic        cbin;
    sent = 0; got = 0; cyc = 0; have = 0; prev_stall = 0;
    ca = '0; cb = '0; cbin = 1'b0;
    held = '{16'd0, 1'b0, 1'b0, 1'b0};
    while (got < nwords && cyc < budget) begin
      @(negedge clk);
      if (rnd) bus.out_ready = ($urandom_range(3) != 0);
      else     bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (!have && sent < nwords) begin
        if (rnd) begin
          ca = 16'($urandom); cb = 16'($urandom); cbin = 1'($urandom);
        end else begin
          ca = vec[sent].a; cb = vec[sent].b; cbin = vec[sent].bin;
        end
        have = 1'b1;
      end
      bus.in_valid = have && (rnd ? ($urandom_range(3) != 0) : 1'b1);
      bus.a   = ca;
      bus.b   = cb;
      bus.bin = cbin;
      #1;
      if (prev_stall)
        chk("stall_hold", {12'd0, bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero},
                          {12'd0, 1'b1, held.d, held.bo, held.ov, held.z});
      exp_ir = (q.size() - int'(bus.out_valid) <= 0) || !bus.out_valid || bus.out_ready;
      chk("stream_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ir});
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_r = q.pop_front();
          chk("stream_word", {13'd0, bus.diff, bus.bout, bus.ovf, bus.zero},
                             {13'd0, exp_r.d, exp_r.bo, exp_r.ov, exp_r.z});
        end
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held = '{bus.diff, bus.bout, bus.ovf, bus.zero};
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(ca, cb, cbin));
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream_done", got, nwords);
    $display("stream rnd=%0d words=%0d received=%0d cycles=%0d", rnd, nwords, got, cyc);
  endtask

  initial begin
    vec[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vec[4]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vec[6]  = '{16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{16'h0800, 16'h0001, 1'b0, 16'h07FF, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vec[10] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vec[11] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("reset_state", {12'd0, bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) apply_vec(i);

    run_stream(8, 1'b0, 200);

    // Async reset with two words in flight, applied between clock edges.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 16'h0005; bus.b = 16'h0003; bus.bin = 1'b0;
    @(negedge clk);
    bus.a = 16'h0800; bus.b = 16'h0001; bus.bin = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("pre_reset_full", {15'd0, bus.out_valid, bus.diff}, {15'd0, 1'b1, 16'h0002});
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset", {12'd0, bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("no_ghost_out", {31'd0, bus.out_valid}, 32'd0);
    end
    apply_vec(5);

    run_stream(10000, 1'b1, 60000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_sub16_pipe.md
Name: csa_sub16_pipe

Overview:
- 16-bit pipelined subtractor: diff = a − b − bin, with borrow-out, signed-overflow and zero flags.
- Uses the same carry-select partitioning as our 16-bit carry-select adder: groups of 2, 2, 3, 4 and 5 bits.
- The partitioning is split across two register stages, with valid/ready handshakes on both sides.
- Sits in the datapath next to the adder and shares its operand bus; consumers use it for compare and decrement paths.

Parameters:
- None. Width is fixed at 16 and the group partition is fixed at 2/2/3/4/5.

Ports:
- clk        input   1   clock; all state updates on the rising edge
- rst        input   1   asynchronous, active-high reset
- in_valid   input   1   operand word valid
- in_ready   output  1   block can accept an operand word this cycle
- a          input   16  minuend
- b          input   16  subtrahend
- bin        input   1   borrow-in (1 = subtract an extra 1)
- out_valid  output  1   result word valid
- out_ready  input   1   downstream accepts the result this cycle
- diff       output  16  a − b − bin, modulo 2^16
- bout       output  1   borrow-out; 1 when unsigned a < b + bin
- ovf        output  1   two's-complement overflow
- zero       output  1   diff == 16'h0000

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-high.
  - While rst = 1: all valid flags clear, diff = 0, bout = 0, ovf = 0, zero = 0.
  - Data registers also reset to 0.
- Arithmetic:
  - Computed as a + ~b + cin, with cin = ~bin.
  - bout = ~carry-out of bit 15.
  - ovf = (a[15] != b[15]) && (diff[15] != a[15]).
  - zero is computed from the final diff.
- Carry selection:
  - Each group above the lowest computes both the carry = 0 and carry = 1 result.
  - The incoming group carry selects between them.
  - The lowest group (bits 1:0) ripples from cin.
- Stage 1 (S1):
  - On accept (in_valid && in_ready), resolves bits 6:0 (groups 2/2/3) and the carry into bit 7.
  - Registers diff[6:0], that carry, a[15:7], ~b[15:7], a[15] and b[15].
  - Sets s1_valid.
- Stage 2 (S2):
  - Resolves bits 15:7 (groups 4/5), bout, ovf and zero.
  - Registers them into the output registers and sets out_valid.
- Latency and throughput:
  - Exactly 2 cycles from accept to out_valid when not stalled.
  - Throughput is 1 word per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, derived combinationally from state and out_ready only; it must not depend on in_valid.
- Stall and bubbles:
  - Stall: with out_valid = 1 and out_ready = 0, the outputs hold stable, S1 holds, and in_ready = 0 once S1 is full.
  - Bubbles collapse: an empty S2 accepts from S1 even while the output is stalled only if out_valid = 0.
- Simultaneous events:
  - out_ready and a new accept in the same cycle: the output takes the S1 word, S1 takes the new word, and nothing is lost or duplicated.
  - When S1 is empty and S2 advances, out_valid drops the next cycle unless S1 held a word.
- Output stability and ordering:
  - The output is registered and remains constant while out_valid && !out_ready.
  - Results come out in acceptance order.
- Reset mid-operation: in-flight words are discarded and no output is produced for them after reset is released.
- Boundary rules:
  - Wrap-around is modulo 2^16.
  - bin = 1 with a = b gives diff = 16'hFFFF and bout = 1.

Test Plan:
- Single op: a=16'h0005, b=16'h0003, bin=0 → after 2 cycles diff=16'h0002, bout=0, ovf=0, zero=0.
- Underflow and zero:
  - a=16'h0000, b=16'h0001, bin=0 → diff=16'hFFFF, bout=1, ovf=0.
  - a=16'h1234, b=16'h1234, bin=1 → diff=16'hFFFF, bout=1.
  - a=16'h00FF, b=16'h00FF, bin=0 → diff=0, zero=1.
- Signed overflow:
  - a=16'h8000, b=16'h0001 → diff=16'h7FFF, ovf=1, bout=0.
  - a=16'h7FFF, b=16'hFFFF → diff=16'h8000, ovf=1, bout=1.
- Carry-select boundaries: a=16'h0080, b=16'h0001 → diff=16'h007F; a=16'h0800, b=16'h0001 → 16'h07FF. Both carries cross the bit-7 and bit-11 group edges.
- Back-to-back with backpressure:
  - Stimulus: 8 consecutive words with out_ready held low for cycles 3–6.
  - Required: in_ready low once both stages are full; outputs stable while stalled; all 8 results correct and in order.
  - Also check against random a/b/bin over 10k words against a reference model.
- Async reset: assert rst mid-stream with 2 words in flight → out_valid=0 and all outputs 0 immediately, without waiting for a clock edge. After release, the next accepted word gives the correct result 2 cycles later.
